sha256_msg_sched: RTL and testbench

Message-schedule and round-constant generator that feeds main_loop. It accepts four 512-bit blocks, one per interleaved hash lane. It then streams one W/K word pair per cycle in lane-interleaved order (lane = cycle mod 4) for 256 cycles, covering 64 rounds × 4 lanes. It also generates main_loop's clr/update controls and reports completion.

---
 rtl/sha256_msg_sched_if.sv | 31 +++
 rtl/sha256_msg_sched.sv | 150 +++++++++++++++
 tb/tb_sha256_msg_sched.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_sched_if.sv
// Block-load handshake and W/K stream bundle between the block source,
// the message scheduler and main_loop.
interface sha256_msg_sched_if;
  logic [511:0] blk_i;
  logic         blk_first_i;
  logic         blk_valid_i;
  logic         blk_ready_o;
  logic [31:0]  w_o;
  logic [31:0]  k_o;
  logic         wk_valid_o;
  logic [1:0]   lane_o;
  logic [5:0]   round_o;
  logic         clr_o;
  logic         update_o;
  logic         done_o;
  logic         busy_o;

  // Scheduler side.
  modport slave (
    input  blk_i, blk_first_i, blk_valid_i,
    output blk_ready_o, w_o, k_o, wk_valid_o, lane_o, round_o,
    output clr_o, update_o, done_o, busy_o
  );

  // Block source / observer side.
  modport master (
    output blk_i, blk_first_i, blk_valid_i,
    input  blk_ready_o, w_o, k_o, wk_valid_o, lane_o, round_o,
    input  clr_o, update_o, done_o, busy_o
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule and round-constant generator for four interleaved
// hash lanes. Loads four blocks, optionally clears main_loop state, streams
// 64 rounds x 4 lanes of W/K, then pulses update per lane and done.
module sha256_msg_sched #(
  parameter int unsigned UPD_DLY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  sha256_msg_sched_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StClr, StRun, StTail} state_e;

  localparam logic [8:0] TailLast = 9'(255 + UPD_DLY);
  // update_q is registered, so it is armed one cycle before its window.
  localparam logic [8:0] UpdArmLo = 9'(251 + UPD_DLY);
  localparam logic [8:0] UpdArmHi = 9'(254 + UPD_DLY);

  localparam logic [31:0] KRom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_e       state_q;
  logic [1:0]   lcnt_q;
  logic         first_q;
  logic [8:0]   cnt_q;
  logic         update_q;
  logic         done_q;
  logic [511:0] blk_q  [4];
  // hist_q[n-1] holds the word emitted n cycles ago, i.e. n/4 rounds back in the same lane.
  logic [31:0]  hist_q [64];

  logic         run;
  logic         accept;
  logic         upd_arm;
  logic [1:0]   lane;
  logic [5:0]   rnd;
  logic [511:0] blk_sel;
  logic [31:0]  w_blk;
  logic [31:0]  w_exp;
  logic [31:0]  w;
  logic [31:0]  k;

  // Datapath decode: current lane/round, message word or expansion, round constant.
  always_comb begin
    run     = (state_q == StRun);
    accept  = (state_q == StIdle) && bus_io.blk_valid_i;
    lane    = cnt_q[1:0];
    rnd     = cnt_q[7:2];
    blk_sel = blk_q[lane];
    w_blk   = blk_sel[32*(15 - int'(rnd[3:0])) +: 32];
    w_exp   = sig1(hist_q[7]) + hist_q[27] + sig0(hist_q[59]) + hist_q[63];
    w       = '0;
    k       = '0;
    if (run) begin
      w = (rnd[5:4] == 2'b00) ? w_blk : w_exp;
      k = KRom[rnd];
    end
    upd_arm = ((state_q == StRun) || (state_q == StTail)) &&
              (cnt_q >= UpdArmLo) && (cnt_q <= UpdArmHi);
  end

  // Control FSM with load/cycle counters and registered update/done pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      lcnt_q   <= 2'd0;
      first_q  <= 1'b0;
      cnt_q    <= 9'd0;
      update_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      update_q <= upd_arm;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            lcnt_q <= lcnt_q + 2'd1;
            if (lcnt_q == 2'd0) first_q <= bus_io.blk_first_i;
            if (lcnt_q == 2'd3) begin
              cnt_q   <= 9'd0;
              state_q <= first_q ? StClr : StRun;
            end
          end
        end
        StClr: begin
          if (cnt_q == 9'd3) begin
            cnt_q   <= 9'd0;
            state_q <= StRun;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        StRun: begin
          // Count continues through TAIL so the update window is one compare.
          cnt_q <= cnt_q + 9'd1;
          if (cnt_q == 9'd255) state_q <= StTail;
        end
        StTail: begin
          if (cnt_q == TailLast) begin
            cnt_q   <= 9'd0;
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
      endcase
    end
  end

  // Block storage and schedule history; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (accept) blk_q[lcnt_q] <= bus_io.blk_i;
    if (run) begin
      hist_q[0] <= w;
      for (int i = 1; i < 64; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign bus_io.blk_ready_o = (state_q == StIdle);
  assign bus_io.w_o         = w;
  assign bus_io.k_o         = k;
  assign bus_io.wk_valid_o  = run;
  assign bus_io.lane_o      = run ? lane : 2'd0;
  assign bus_io.round_o     = run ? rnd : 6'd0;
  assign bus_io.clr_o       = (state_q == StClr);
  assign bus_io.update_o    = update_q;
  assign bus_io.done_o      = done_q;
  assign bus_io.busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: spot-value table for the "abc" block, a per-lane
// software schedule model (K derived from cube roots of primes), and
// hand-written load/stall/reset sequences.
module tb_sha256_msg_sched;
  localparam int UpdDly = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_msg_sched_if bus ();

  sha256_msg_sched #(.UPD_DLY(UpdDly)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  typedef struct {
    string       name;
    int          lane;
    int          rnd;
    bit          is_k;
    logic [31:0] exp;
  } spot_t;

  int           checks   = 0;
  int           failures = 0;
  int           accepts  = 0;
  logic [511:0] blks  [4];
  logic [31:0]  kref  [64];
  logic [31:0]  wref  [4][64];
  logic [31:0]  obs_w [4][64];
  logic [31:0]  obs_k [4][64];
  spot_t        spots [8];

  // Count handshakes mid-cycle, away from the clock edge.
  always @(negedge clk) if (!rst && bus.blk_valid_i && bus.blk_ready_o) accepts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  // K[t] = first 32 fractional bits of the cube root of the t-th prime.
  task automatic gen_k();
    int  n;
    real r, f;
    bit  is_p;
    n = 0;
    for (int p = 2; n < 64; p++) begin
      is_p = 1'b1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) is_p = 1'b0;
      if (is_p) begin
        r = $pow(real'(p), 1.0 / 3.0);
        f = r - $floor(r);
        kref[n] = 32'(longint'($floor(f * 4294967296.0)));
        n++;
      end
    end
  endtask

  task automatic build_model();
    logic [31:0] s0, s1;
    for (int l = 0; l < 4; l++) begin
      for (int t = 0; t < 16; t++) wref[l][t] = blks[l][511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
        s0 = rotr(wref[l][t-15], 7) ^ rotr(wref[l][t-15], 18) ^ (wref[l][t-15] >> 3);
        s1 = rotr(wref[l][t-2], 17) ^ rotr(wref[l][t-2], 19) ^ (wref[l][t-2] >> 10);
        wref[l][t] = s1 + wref[l][t-7] + s0 + wref[l][t-16];
      end
    end
  endtask

  task automatic rand_blocks();
    for (int l = 0; l < 4; l++)
      for (int j = 0; j < 16; j++) blks[l][32*j +: 32] = $urandom();
  endtask

  // Present lanes start..3; blk_first_i on lanes 1..3 is the inverse to show it is ignored.
  task automatic load(input int start, input bit first, input int gap);
    for (int l = start; l < 4; l++) begin
      bus.blk_i       = blks[l];
      bus.blk_first_i = (l == 0) ? first : !first;
      bus.blk_valid_i = 1'b1;
      chk($sformatf("ready_lane%0d", l), bus.blk_ready_o, 1);
      tick();
      bus.blk_valid_i = 1'b0;
      if (l < 3) begin
        repeat (gap) begin
          chk("gap_ready", bus.blk_ready_o, 1);
          chk("gap_wkv", bus.wk_valid_o, 0);
          tick();
        end
      end
    end
  endtask

  // Follow one operation from the cycle after the 4th handshake to done.
  task automatic observe(input bit first, input int abort_at);
    bit seen;
    if (first) begin
      for (int i = 0; i < 4; i++) begin
        chk("clr_o", bus.clr_o, 1);
        chk("clr_ready", bus.blk_ready_o, 0);
        chk("clr_wkv", bus.wk_valid_o, 0);
        chk("clr_upd", bus.update_o, 0);
        chk("clr_busy", bus.busy_o, 1);
        tick();
      end
    end
    for (int c = 0; c < 256 + UpdDly; c++) begin
      chk("run_clr", bus.clr_o, 0);
      chk("run_busy", bus.busy_o, 1);
      chk("run_ready", bus.blk_ready_o, 0);
      chk("run_done", bus.done_o, 0);
      chk($sformatf("update_o c%0d", c), bus.update_o,
          32'((c >= 252 + UpdDly) && (c <= 255 + UpdDly)));
      if (c < 256) begin
        obs_w[c % 4][c / 4] = bus.w_o;
        obs_k[c % 4][c / 4] = bus.k_o;
        chk("wk_valid", bus.wk_valid_o, 1);
        chk($sformatf("lane_o c%0d", c), bus.lane_o, c % 4);
        chk($sformatf("round_o c%0d", c), bus.round_o, c / 4);
        chk($sformatf("w_o l%0d r%0d", c % 4, c / 4), bus.w_o, wref[c % 4][c / 4]);
        chk($sformatf("k_o r%0d", c / 4), bus.k_o, kref[c / 4]);
      end else begin
        chk("tail_wkv", bus.wk_valid_o, 0);
        chk("tail_w", bus.w_o, 0);
        chk("tail_k", bus.k_o, 0);
      end
      if (c == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", bus.blk_ready_o, 1);
        chk("rst_wkv", bus.wk_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_clr", bus.clr_o, 0);
        seen = 1'b0;
        repeat (300) begin
          if (bus.update_o || bus.done_o || bus.wk_valid_o) seen = 1'b1;
          tick();
        end
        chk("no_activity_after_reset", seen, 0);
        return;
      end
      tick();
    end
    chk("done_o", bus.done_o, 1);
    chk("done_ready", bus.blk_ready_o, 1);
    chk("done_busy", bus.busy_o, 0);
    chk("done_upd", bus.update_o, 0);
    tick();
    chk("done_pulse_end", bus.done_o, 0);
  endtask

  initial begin : main
    logic [511:0] abc;
    logic [511:0] held;
    bit           first;
    int           a0;

    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [511:0] abc;
    logic [511:0] held;
    bit           first;
    int           a0;

    gen_k();
    spots[0] = '{"abc_l0_r0_w",  0, 0,  1'b0, 32'h61626380};
    spots[1] = '{"abc_l0_r0_k",  0, 0,  1'b1, 32'h428a2f98};
    spots[2] = '{"abc_l0_r16_w", 0, 16, 1'b0, 32'h61626380};
    spots[3] = '{"abc_l0_r17_w", 0, 17, 1'b0, 32'h000f0000};
    spots[4] = '{"abc_l0_r18_w", 0, 18, 1'b0, 32'h7da86405};
    spots[5] = '{"abc_l0_r63_k", 0, 63, 1'b1, 32'hc67178f2};
    spots[6] = '{"abc_l3_r0_w",  3, 0,  1'b0, 32'h61626380};
    spots[7] = '{"abc_l2_r17_w", 2, 17, 1'b0, 32'h000f0000};

    bus.blk_i       = '0;
    bus.blk_first_i = 1'b0;
    bus.blk_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_ready", bus.blk_ready_o, 1);
    chk("reset_wkv", bus.wk_valid_o, 0);
    chk("reset_clr", bus.clr_o, 0);
    chk("reset_upd", bus.update_o, 0);
    chk("reset_done", bus.done_o, 0);
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_w", bus.w_o, 0);
    chk("reset_k", bus.k_o, 0);
    chk("reset_lane", bus.lane_o, 0);
    chk("reset_round", bus.round_o, 0);
    rst = 1'b0;
    tick();

    // "abc" padded block in every lane, new message.
    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;
    for (int l = 0; l < 4; l++) blks[l] = abc;
    build_model();
    load(0, 1'b1, 0);
    observe(1'b1, -1);
    for (int i = 0; i < 8; i++)
      chk(spots[i].name,
          spots[i].is_k ? obs_k[spots[i].lane][spots[i].rnd] : obs_w[spots[i].lane][spots[i].rnd],
          spots[i].exp);

    // Lane L: every word L+1.
    for (int l = 0; l < 4; l++) blks[l] = {16{32'(l + 1)}};
    build_model();
    load(0, 1'b1, 0);
    observe(1'b1, -1);
    chk("distinct_l2_r5", obs_w[2][5], 32'd3);

    // Continuation group: no clear, RUN right after the 4th handshake.
    load(0, 1'b0, 0);
    observe(1'b0, -1);

    // Random blocks with gaps between handshakes.
    for (int r = 0; r < 3; r++) begin
      rand_blocks();
      build_model();
      first = 1'($urandom_range(0, 1));
      a0 = accepts;
      load(0, first, (r == 0) ? 2 : int'($urandom_range(0, 3)));
      chk("accepts_per_load", accepts - a0, 4);
      observe(first, -1);
    end

    // blk_valid_i held through the whole operation: only accepted at done.
    rand_blocks();
    build_model();
    load(0, 1'b1, 0);
    held = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
    bus.blk_i       = held;
    bus.blk_first_i = 1'b0;
    bus.blk_valid_i = 1'b1;
    a0 = accepts;
    observe(1'b1, -1);
    bus.blk_valid_i = 1'b0;
    chk("held_valid_accepts", accepts - a0, 1);
    rand_blocks();
    blks[0] = held;
    build_model();
    load(1, 1'b0, 0);
    observe(1'b0, -1);

    // Reset at c = 100, then a full normal run.
    rand_blocks();
    build_model();
    load(0, 1'b1, 0);
    observe(1'b1, 100);
    rand_blocks();
    build_model();
    load(0, 1'b1, 1);
    observe(1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
